// File: rtl/ball_pkg.sv
// Shared constants for the ball datapath: screen bounds, colours, plotter
// handshake width and the sequencer state encoding.
package ball_pkg;

  localparam int COL_W = 3;

  localparam logic [7:0] X_MAX = 8'd159;
  localparam logic [6:0] Y_MAX = 7'd119;

  localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
  localparam logic [COL_W-1:0] COL_WHITE = 3'b111;

  // Sequencer states, kept as plain constants so older blocks can match on them.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DRAW   = 3'd1;
  localparam state_t ST_WAIT   = 3'd2;
  localparam state_t ST_ERASE  = 3'd3;
  localparam state_t ST_UPDATE = 3'd4;
  localparam state_t ST_MISS   = 3'd5;

endpackage

// File: rtl/ball_if.sv
// Pixel plotter request/acknowledge channel; the ball sequencer is the master.
interface ball_if;
  import ball_pkg::*;

  logic             plot_req;
  logic             plot_ack;
  logic [7:0]       plot_x;
  logic [6:0]       plot_y;
  logic [COL_W-1:0] plot_colour;

  modport master (
    output plot_req, plot_x, plot_y, plot_colour,
    input  plot_ack
  );

  modport slave (
    input  plot_req, plot_x, plot_y, plot_colour,
    output plot_ack
  );

endinterface

// File: rtl/ball_axis.sv
// One ball coordinate: up/down counter that reloads its start value and
// exposes the candidate next position so the caller can plot it early.
module ball_axis #(
  parameter int           W     = 8,
  parameter logic [W-1:0] START = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] pos,
  output logic [W-1:0] step_pos
);

  assign step_pos = up ? pos + W'(1) : pos - W'(1);

  always_ff @(posedge clk) begin
    if (!resetn || load) begin
      pos <= START;
    end else if (en) begin
      pos <= step_pos;
    end
  end

endmodule

// File: rtl/ball_ctrl.sv
// Ball sequencer: once per animation step it erases the old pixel, applies
// the bounce rules, moves the ball and draws it again via the shared plotter.
module ball_ctrl
  import ball_pkg::*;
#(
  parameter logic [7:0]       X_START   = 8'd80,
  parameter logic [6:0]       Y_START   = 7'd60,
  parameter int               PADDLE_Y  = 112,
  parameter int               PADDLE_W  = 16,
  parameter int               SPEED_DIV = 2,
  parameter logic [COL_W-1:0] BALL_COL  = COL_WHITE
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       frame_tick,
  input  logic [7:0] paddle_x,
  input  logic       brick_hit,
  ball_if.master     plot,
  output logic [7:0] ball_x,
  output logic [6:0] ball_y,
  output logic       x_du,
  output logic       y_du,
  output logic       miss,
  output logic       busy
);

  localparam logic [6:0] PAD_ROW  = 7'(PADDLE_Y - 1);
  localparam logic [3:0] DIV_LAST = 4'(SPEED_DIV - 1);
  localparam logic [8:0] PAD_SPAN = 9'(PADDLE_W - 1);

  state_t     state;
  logic [3:0] div;

  logic       x_du_n;
  logic       y_du_n;
  logic       miss_hit;
  logic       wall_flip;
  logic       paddle_flip;
  logic       in_paddle;
  logic       reload;
  logic       step_en;
  logic [7:0] x_step;
  logic [6:0] y_step;
  logic [8:0] pad_lo;
  logic [8:0] pad_hi;
  logic [8:0] ball_x9;

  // Paddle span is compared one bit wider so a paddle near column 255 cannot wrap.
  assign ball_x9   = {1'b0, ball_x};
  assign pad_lo    = {1'b0, paddle_x};
  assign pad_hi    = pad_lo + PAD_SPAN;
  assign in_paddle = (ball_x9 >= pad_lo) && (ball_x9 <= pad_hi);

  always_comb begin
    miss_hit    = y_du && (ball_y == Y_MAX);
    wall_flip   = !y_du && (ball_y == 7'd0);
    paddle_flip = y_du && (ball_y == PAD_ROW) && in_paddle;

    x_du_n = x_du;
    if (x_du && (ball_x == X_MAX)) begin
      x_du_n = 1'b0;
    end else if (!x_du && (ball_x == 8'd0)) begin
      x_du_n = 1'b1;
    end

    // A brick only reverses the ball when no wall or paddle already did.
    y_du_n = y_du;
    if (wall_flip) begin
      y_du_n = 1'b1;
    end else if (paddle_flip) begin
      y_du_n = 1'b0;
    end else if (brick_hit) begin
      y_du_n = !y_du;
    end
  end

  assign reload  = (state == ST_MISS);
  assign step_en = (state == ST_UPDATE) && !miss_hit;
  assign busy    = (state != ST_IDLE);
  assign miss    = (state == ST_MISS);

  ball_axis #(.W(8), .START(X_START)) u_axis_x (
    .clk      (clk),
    .resetn   (resetn),
    .load     (reload),
    .en       (step_en),
    .up       (x_du_n),
    .pos      (ball_x),
    .step_pos (x_step)
  );

  ball_axis #(.W(7), .START(Y_START)) u_axis_y (
    .clk      (clk),
    .resetn   (resetn),
    .load     (reload),
    .en       (step_en),
    .up       (y_du_n),
    .pos      (ball_y),
    .step_pos (y_step)
  );

  // Plot outputs are registered and loaded on entry to DRAW/ERASE, so they
  // stay frozen for as long as the plotter withholds its acknowledge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      div              <= '0;
      x_du             <= 1'b1;
      y_du             <= 1'b0;
      plot.plot_req    <= 1'b0;
      plot.plot_x      <= '0;
      plot.plot_y      <= '0;
      plot.plot_colour <= COL_BLACK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            state            <= ST_DRAW;
            plot.plot_req    <= 1'b1;
            plot.plot_x      <= ball_x;
            plot.plot_y      <= ball_y;
            plot.plot_colour <= BALL_COL;
          end
        end
        ST_DRAW: begin
          if (plot.plot_ack) begin
            plot.plot_req <= 1'b0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (frame_tick) begin
            if (div == DIV_LAST) begin
              div              <= '0;
              state            <= ST_ERASE;
              plot.plot_req    <= 1'b1;
              plot.plot_x      <= ball_x;
              plot.plot_y      <= ball_y;
              plot.plot_colour <= COL_BLACK;
            end else begin
              div <= div + 4'd1;
            end
          end
        end
        ST_ERASE: begin
          if (plot.plot_ack) begin
            plot.plot_req <= 1'b0;
            state         <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (miss_hit) begin
            state <= ST_MISS;
          end else begin
            x_du             <= x_du_n;
            y_du             <= y_du_n;
            state            <= ST_DRAW;
            plot.plot_req    <= 1'b1;
            plot.plot_x      <= x_step;
            plot.plot_y      <= y_step;
            plot.plot_colour <= BALL_COL;
          end
        end
        ST_MISS: begin
          x_du  <= 1'b1;
          y_du  <= 1'b0;
          div   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: hand-checked opening moves from a table, then a long
// randomized game compared against a simple position/velocity model.
module tb_ball_ctrl;
  import ball_pkg::*;

  localparam int SPEED_DIV = 2;

  logic       clk;
  logic       resetn;
  logic       go;
  logic       frame_tick;
  logic [7:0] paddle_x;
  logic       brick_hit;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       x_du;
  logic       y_du;
  logic       miss;
  logic       busy;

  ball_if bus ();

  ball_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .go         (go),
    .frame_tick (frame_tick),
    .paddle_x   (paddle_x),
    .brick_hit  (brick_hit),
    .plot       (bus),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .x_du       (x_du),
    .y_du       (y_du),
    .miss       (miss),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference ball: position plus a signed velocity of +1/-1 per axis.
  int mx, my, mdx, mdy;

  typedef struct {
    bit brick;
    int pad;
    int hold;
    int exp_x;
    int exp_y;
    bit exp_xd;
    bit exp_yd;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit g, input bit t, input bit b, input int p);
    go         = g;
    frame_tick = t;
    brick_hit  = b;
    paddle_x   = 8'(p);
  endtask

  task automatic model_reset();
    mx  = 80;
    my  = 60;
    mdx = 1;
    mdy = -1;
  endtask

  task automatic model_update(input bit brick, input int pad, output bit lost);
    bit flipped;
    flipped = 0;
    lost    = 0;
    if (mdy == 1 && my == 119) begin
      lost = 1;
    end else begin
      if (mx + mdx > 159 || mx + mdx < 0) mdx = -mdx;
      if (mdy == -1 && my == 0) begin
        mdy = 1;
        flipped = 1;
      end else if (mdy == 1 && my == 111 && mx >= pad && mx <= pad + 15) begin
        mdy = -1;
        flipped = 1;
      end
      if (brick && !flipped) mdy = -mdy;
      mx += mdx;
      my += mdy;
    end
  endtask

  task automatic check_ball(input string tag);
    checkOutput({tag, "_ball_x"}, ball_x, mx);
    checkOutput({tag, "_ball_y"}, ball_y, my);
    checkOutput({tag, "_x_du"}, x_du, (mdx > 0));
    checkOutput({tag, "_y_du"}, y_du, (mdy > 0));
  endtask

  // Starts a serve from IDLE; leaves time at the negedge showing the draw.
  task automatic serve();
    bus.plot_ack = 1'b1;
    applyStimulus(1, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    model_reset();
    checkOutput("serve_req", bus.plot_req, 1);
    checkOutput("serve_x", bus.plot_x, 80);
    checkOutput("serve_y", bus.plot_y, 60);
    checkOutput("serve_colour", bus.plot_colour, 7);
    checkOutput("serve_busy", busy, 1);
  endtask

  // One animation step starting at a draw negedge: frame ticks, erase
  // (optionally stalled for 'hold' cycles), update, then draw or miss.
  task automatic run_step(input bit brick, input int pad, input int hold, output bit lost);
    int ticks, budget;
    bit first;
    ticks  = 0;
    budget = 0;
    first  = 1;
    lost   = 0;
    bus.plot_ack = 1'b1;
    while (ticks < SPEED_DIV && budget < 64) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), brick, pad);
      if (frame_tick && !first) ticks++;
      first = 0;
      @(negedge clk);
      budget++;
      checkOutput("erase_timing", bus.plot_req, (ticks == SPEED_DIV));
    end
    applyStimulus(0, 0, brick, pad);
    if (ticks < SPEED_DIV) begin
      checks++;
      errors++;
      $display("[TB] FAIL tick_budget: got %0d ticks required %0d", ticks, SPEED_DIV);
      return;
    end
    checkOutput("erase_x", bus.plot_x, mx);
    checkOutput("erase_y", bus.plot_y, my);
    checkOutput("erase_colour", bus.plot_colour, 0);
    checkOutput("erase_busy", busy, 1);
    if (hold > 0) begin
      bus.plot_ack = 1'b0;
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        checkOutput("hold_req", bus.plot_req, 1);
        checkOutput("hold_x", bus.plot_x, mx);
        checkOutput("hold_y", bus.plot_y, my);
        checkOutput("hold_colour", bus.plot_colour, 0);
      end
      bus.plot_ack = 1'b1;
    end
    model_update(brick, pad, lost);
    @(negedge clk);
    checkOutput("ack_drop", bus.plot_req, 0);
    checkOutput("update_miss", miss, 0);
    @(negedge clk);
    if (lost) begin
      checkOutput("miss_pulse", miss, 1);
      checkOutput("miss_req", bus.plot_req, 0);
      @(negedge clk);
      model_reset();
      checkOutput("miss_end", miss, 0);
      checkOutput("miss_idle", busy, 0);
      check_ball("reload");
    end else begin
      checkOutput("draw_req", bus.plot_req, 1);
      checkOutput("draw_x", bus.plot_x, mx);
      checkOutput("draw_y", bus.plot_y, my);
      checkOutput("draw_colour", bus.plot_colour, 7);
      check_ball("draw");
    end
  endtask

  task automatic idle_quiet();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), 0, 0);
      @(negedge clk);
      checkOutput("idle_req", bus.plot_req, 0);
      checkOutput("idle_busy", busy, 0);
    end
    applyStimulus(0, 0, 0, 0);
  endtask

  initial begin
    bit lost;
    int pad, sel, hold;
    bit brick;

    checks = 0;
    errors = 0;

    // Opening moves from the serve, worked out by hand.
    vecs[0] = '{0, 0, 10, 81, 59, 1, 0};
    vecs[1] = '{1, 0, 0, 82, 60, 1, 1};
    vecs[2] = '{0, 0, 0, 83, 61, 1, 1};
    vecs[3] = '{1, 0, 0, 84, 60, 1, 0};
    vecs[4] = '{0, 0, 0, 85, 59, 1, 0};

    resetn = 1'b0;
    bus.plot_ack = 1'b0;
    applyStimulus(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("rst_req", bus.plot_req, 0);
    checkOutput("rst_plot_x", bus.plot_x, 0);
    checkOutput("rst_plot_y", bus.plot_y, 0);
    checkOutput("rst_colour", bus.plot_colour, 0);
    checkOutput("rst_ball_x", ball_x, 80);
    checkOutput("rst_ball_y", ball_y, 60);
    checkOutput("rst_x_du", x_du, 1);
    checkOutput("rst_y_du", y_du, 0);
    checkOutput("rst_miss", miss, 0);
    checkOutput("rst_busy", busy, 0);
    resetn = 1'b1;
    idle_quiet();

    serve();
    for (int i = 0; i < 5; i++) begin
      run_step(vecs[i].brick, vecs[i].pad, vecs[i].hold, lost);
      checkOutput("vec_x", ball_x, vecs[i].exp_x);
      checkOutput("vec_y", ball_y, vecs[i].exp_y);
      checkOutput("vec_x_du", x_du, vecs[i].exp_xd);
      checkOutput("vec_y_du", y_du, vecs[i].exp_yd);
    end

    for (int n = 0; n < 700; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0:       pad = mx - 15;
        1:       pad = mx;
        2:       pad = mx + 1;
        3:       pad = mx - 16;
        default: pad = $urandom_range(0, 255);
      endcase
      if (pad < 0 || pad > 255) pad = $urandom_range(0, 255);
      brick = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
      run_step(brick, pad, hold, lost);
      if (lost) begin
        idle_quiet();
        serve();
      end
    end

    // Reset while a draw is pending must drop the request on the next cycle.
    bus.plot_ack = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("rst_draw_req", bus.plot_req, 0);
    checkOutput("rst_draw_busy", busy, 0);
    checkOutput("rst_draw_ball_x", ball_x, 80);
    checkOutput("rst_draw_ball_y", ball_y, 60);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_req", bus.plot_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_ctrl.md
Name: ball_ctrl

Overview:
- Sequences the ball datapath once per animation frame: erase old pixel, compute bounce directions, step the position, draw the new pixel.
- Owns the x/y position counters and their up/down directions.
- Shares the pixel plotter through a req/ack handshake.
- Reports a miss to game-level control when the ball passes the paddle line.

Parameters:
- X_MAX, 159, rightmost pixel column (screen 160x120)
- Y_MAX, 119, bottom pixel row
- X_START, 80, serve column
- Y_START, 60, serve row
- PADDLE_Y, 112, paddle row; the ball bounces off the row above it
- PADDLE_W, 16, paddle width in pixels
- SPEED_DIV, 2, frame_ticks per ball step (1..15)
- BALL_COL, 3'b111, draw colour; erase colour is 3'b000

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; synchronous, active-low
- go  in  1  serve request; honoured only in IDLE
- frame_tick  in  1  one-cycle pulse per video frame
- paddle_x  in  8  left column of paddle
- brick_hit  in  1  brick-collision flag; level, sampled only in UPDATE
- plot_ack  in  1  plotter accepted current request
- plot_req  out  1  pixel plot request
- plot_x  out  8  plot column
- plot_y  out  7  plot row
- plot_colour  out  3  plot colour
- ball_x  out  8  current ball column
- ball_y  out  7  current ball row
- x_du  out  1  1 = moving right (+1), 0 = left
- y_du  out  1  1 = moving down (+1), 0 = up
- miss  out  1  one-cycle pulse when ball lost
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: state IDLE; plot_req=0, plot_x=0, plot_y=0, plot_colour=0; ball_x=X_START, ball_y=Y_START; x_du=1, y_du=0; miss=0; frame divider=0.
- Reset mid-operation aborts any plot immediately: plot_req is 0 on the cycle after resetn sampled low.
- States: IDLE, DRAW, WAIT, ERASE, UPDATE, MISS.
- IDLE: on go go to DRAW.
- DRAW: plot_req=1, plot coords = ball_x/ball_y, colour BALL_COL; hold all until plot_ack=1 sampled; next cycle plot_req=0 and go to WAIT.
- WAIT:
  - Each frame_tick increments the divider.
  - When the divider reaches SPEED_DIV-1 on a tick, clear it and go to ERASE.
  - frame_tick outside WAIT is ignored.
- ERASE: same handshake as DRAW with colour 0; on ack go to UPDATE.
- UPDATE is a single cycle, evaluated from current position and directions:
  - Miss check has priority: y_du=1 and ball_y==Y_MAX means go to MISS; no step.
  - x bounce: x_du=1 and ball_x==X_MAX gives x_du'=0; x_du=0 and ball_x==0 gives x_du'=1; otherwise unchanged.
  - y wall: y_du=0 and ball_y==0 gives y_du'=1.
  - Paddle: y_du=1, ball_y==PADDLE_Y-1, and paddle_x <= ball_x <= paddle_x+PADDLE_W-1 gives y_du'=0. Compare in 9-bit width so paddle_x+PADDLE_W does not wrap.
  - brick_hit=1 inverts y_du only when no wall or paddle flip fired this cycle. Simultaneous events produce exactly one flip.
  - Step: ball_x += x_du' ? +1 : -1; ball_y += y_du' ? +1 : -1. The bounce rules guarantee no wrap.
  - Then go to DRAW.
- MISS:
  - miss=1 for one cycle.
  - ball_x/ball_y reload X_START/Y_START; x_du=1, y_du=0; divider cleared.
  - Go to IDLE. The old pixel is already erased.
- plot_ack is ignored when plot_req=0.
- go while busy is ignored.

Decomposition:
- Shared package ball_pkg:
  - state enum
  - screen constants X_MAX, Y_MAX
  - colour constants COL_BLACK, COL_WHITE
  - plotter handshake colour width (3)
- One sub-module, ball_axis:
  - parameterised width up/down counter with load value, enable, and direction input.
  - Instantiated twice (8-bit x, 7-bit y).
  - Loads the start value on reset/MISS and steps on UPDATE.

Test Plan:
- Reset, go, plot_ack tied 1 -> one DRAW at (80,60) colour 7; WAIT entered; busy=1; no further plot until 2 frame_ticks.
- plot_ack held 0 for 10 cycles in ERASE -> plot_req, plot_x, plot_y, plot_colour stable all 10 cycles; one-cycle drop after ack.
- Force ball to (159,30), x_du=1, y_du=0 -> after one step: x_du=0, y_du=0, position (158,29).
- Ball at (100,111), y_du=1, paddle_x=92 -> y_du=0, next y=110; repeat with paddle_x=101 -> continues to y=112.
- Ball at (40,0), y_du=0, brick_hit=1 -> exactly one flip: y_du=1, y=1; with brick_hit=1 at mid-field y_du=1 -> y_du=0.
- Ball reaches (x,119) moving down -> miss pulses 1 cycle, ball_x=80, ball_y=60, state IDLE, no DRAW until go; assert resetn=0 during DRAW -> plot_req=0 next cycle.
